lfsr_period_monitor: RTL and testbench
======================================

# lfsr_period_monitor

Downstream checker for the 6-bit LFSR stage: it samples the LFSR state bus every clock, captures a reference state on request, and measures how many cycles pass before that state recurs. It reports the sequence period and flags all-zero lock-up, a missing repeat (timeout) and maximal-length sequences. It sits directly on the LFSR `out` bus and gives the verification and BIST logic a single pass/fail result per measurement.

## Interface
Parameters:
- `WIDTH`, default 6: LFSR state width.
- `PW`, default `WIDTH+1`: width of the period counter. Must hold 2**WIDTH.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request a measurement. Sampled only in IDLE or DONE.
- `lfsr_in`, in, `WIDTH`: LFSR state. Connects to the LFSR `out` port.
- `busy`, out, 1: high while in COUNT.
- `done`, out, 1: high while in DONE. It is a level, not a pulse.
- `period`, out, `PW`: measured period. Valid while `done`=1 and `match`=1.
- `match`, out, 1: the reference state recurred.
- `lockup`, out, 1: an all-zero state was seen.
- `timeout`, out, 1: no recurrence within 2**WIDTH cycles.
- `maximal`, out, 1: `match`=1 and `period`==2**WIDTH−1.

## Operation
- State machine with states IDLE, COUNT and DONE.
- **IDLE, or DONE, with `start`=1:**
  - If `lfsr_in`==0: go to DONE with `lockup`=1 and `period`=0.
  - Otherwise: `ref`<=`lfsr_in`, `cnt`<=1, clear all status bits, go to COUNT.
- **DONE with `start`=0:** hold every output.
- **COUNT, checks each cycle in this priority order:**
  1. `lfsr_in`==`ref`: `period`<=`cnt`, `match`<=1, go to DONE.
  2. `lfsr_in`==0: `lockup`<=1, `period`<=`cnt`, go to DONE.
  3. `cnt`==2**WIDTH: `timeout`<=1, `period`<=`cnt`, go to DONE.
  4. Otherwise: `cnt`<=`cnt`+1.
- `start` is ignored in COUNT. A measurement cannot be aborted except by reset.
- In DONE, at most one of `match`, `lockup` and `timeout` is 1.
- `maximal` is decoded combinationally from the registered `match` and `period`.
- Arithmetic:
  - `cnt` is unsigned `PW` bits and never wraps; the timeout check caps it at 2**WIDTH.
  - Compares are full-width equality.

## Timing
- Let `start` be sampled at edge t.
  - `lfsr_in` at edge t becomes `ref`.
  - `cnt` equals k during cycle t+k.
- A recurrence at edge t+k gives `period`=k, and `done` rises after edge t+k (visible in cycle t+k+1).
- Latency from `start` to `done` = period + 1 edges. The worst case is 2**WIDTH+1 edges.
- `busy` is high from after edge t until after the terminating edge.
- A `start` in DONE clears the status bits in the same edge that enters COUNT. `done` falls one cycle after that `start`.
- Reset values, applied asynchronously at any time including mid-COUNT:
  - state = IDLE.
  - `busy`=`done`=`match`=`lockup`=`timeout`=0.
  - `period`=0, `cnt`=0, `ref`=0.

## Structure
- Package `lfsr_mon_pkg`:
  - state enum `lfsr_mon_state_t` (IDLE, COUNT, DONE).
  - constant `LFSR_W`=6.
  - function computing 2**WIDTH−1 for the `maximal` check.
- Single module, no sub-module. The counter, comparator and FSM are small enough to keep inline.
- Registered outputs except `maximal`, which is decoded.

## Test plan
- **Maximal LFSR:** feed `lfsr_in` from the 6-bit LFSR, seeded 6'b101011 and free-running, then pulse `start`. Required: `done` after 64 edges, `match`=1, `period`=63, `maximal`=1.
- **Short cycle:** bench drives the repeating pattern 5, 9, 3, 5, … and pulses `start` on the 5. Required: `period`=3, `match`=1, `maximal`=0, `done` 4 edges after `start`.
- **Lock-up:**
  - Drive 5, 9, 0. Required: `lockup`=1, `period`=2, `match`=0.
  - Pulse `start` while `lfsr_in`=0. Required: DONE on the next edge with `lockup`=1, `period`=0.
- **Timeout:** drive an incrementing sequence 1, 2, … 63 that never returns to 1 within the window. Required: `timeout`=1, `period`=64, `done` 65 edges after `start`.
- **Restart and ignore:**
  - Pulse `start` mid-COUNT. Required: no effect on the result.
  - Pulse `start` in DONE. Required: status cleared, `busy`=1 on the next cycle, new result correct.
- **Reset mid-operation:** drop `rst_n` asynchronously during COUNT (between edges). Required: all outputs 0 immediately, state IDLE. A later `start` measures correctly.

Source files
------------

// File: rtl/lfsr_mon_pkg.sv
// Shared types and constants for the LFSR period monitor.
package lfsr_mon_pkg;

    localparam int unsigned LFSR_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } lfsr_mon_state_t;

    // Period of a maximal-length LFSR of width w: 2**w - 1.
    function automatic int unsigned max_len_period(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state bus from a captured reference,
// flagging lock-up, timeout and maximal-length sequences.
module lfsr_period_monitor
    import lfsr_mon_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W,
    parameter int unsigned PW    = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lfsr_in,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    period,
    output logic             match,
    output logic             lockup,
    output logic             timeout,
    output logic             maximal
);

    localparam logic [PW-1:0] CNT_CAP = PW'(32'd1 << WIDTH);
    localparam logic [PW-1:0] MAX_LEN = PW'(max_len_period(WIDTH));

    lfsr_mon_state_t  state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    period_q, period_d;
    logic             match_q, match_d;
    logic             lockup_q, lockup_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            match_q   <= 1'b0;
            lockup_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            match_q   <= match_d;
            lockup_q  <= lockup_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        match_d   = match_q;
        lockup_d  = lockup_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    match_d   = 1'b0;
                    timeout_d = 1'b0;
                    period_d  = '0;
                    if (lfsr_in == '0) begin
                        // An all-zero reference can never advance, so report lock-up at once.
                        lockup_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        lockup_d = 1'b0;
                        ref_d    = lfsr_in;
                        cnt_d    = PW'(1);
                        state_d  = COUNT;
                    end
                end
            end
            COUNT: begin
                if (lfsr_in == ref_q) begin
                    period_d = cnt_q;
                    match_d  = 1'b1;
                    state_d  = DONE;
                end else if (lfsr_in == '0) begin
                    period_d = cnt_q;
                    lockup_d = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CNT_CAP) begin
                    period_d  = cnt_q;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == COUNT);
        done_d = (state_d == DONE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign period  = period_q;
    assign match   = match_q;
    assign lockup  = lockup_q;
    assign timeout = timeout_q;
    assign maximal = match_q && (period_q == MAX_LEN);

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed self-checking bench for lfsr_period_monitor.
module tb_lfsr_period_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] lfsr_in;
    logic       busy, done, match, lockup, timeout, maximal;
    logic [6:0] period;

    int total = 0;
    int bad   = 0;
    int edges;
    int poke;
    logic busy1, done1, match1;
    logic [5:0] pat[$];

    lfsr_period_monitor #(.WIDTH(6), .PW(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .lfsr_in (lfsr_in),
        .busy    (busy),
        .done    (done),
        .period  (period),
        .match   (match),
        .lockup  (lockup),
        .timeout (timeout),
        .maximal (maximal)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive pat one value per edge, pulse start on the first edge, count edges until done.
    task automatic run_meas(input int max_edges);
        int idx;
        @(negedge clk);
        lfsr_in = pat[0];
        start   = 1'b1;
        edges   = 0;
        for (int i = 1; i <= max_edges; i++) begin
            @(negedge clk);
            edges = i;
            if (i == 1) begin
                busy1  = busy;
                done1  = done;
                match1 = match;
            end
            if (done) break;
            start   = (i == poke);
            idx     = (i < pat.size()) ? i : pat.size() - 1;
            lfsr_in = pat[idx];
        end
        start = 1'b0;
    endtask

    initial begin
        logic [5:0] s;
        rst_n   = 1'b0;
        start   = 1'b0;
        lfsr_in = 6'd0;
        poke    = -1;
        #1;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_flags",  32'({match, lockup, timeout, maximal}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Maximal-length sequence from the real LFSR recurrence
        pat.delete();
        s = 6'b101011;
        for (int k = 0; k < 70; k++) begin
            pat.push_back(s);
            s = lfsr_next(s);
        end
        run_meas(200);
        chk("max_busy1",  32'(busy1),   32'd1);
        chk("max_edges",  32'(edges),   32'd64);
        chk("max_done",   32'(done),    32'd1);
        chk("max_match",  32'(match),   32'd1);
        chk("max_period", 32'(period),  32'd63);
        chk("max_flag",   32'(maximal), 32'd1);
        chk("max_busy",   32'(busy),    32'd0);
        repeat (3) @(negedge clk);
        chk("hold_done",   32'(done),    32'd1);
        chk("hold_period", 32'(period),  32'd63);
        chk("hold_max",    32'(maximal), 32'd1);

        // Short cycle 5,9,3 started from DONE; status must clear on the first edge
        pat = '{6'd5, 6'd9, 6'd3, 6'd5, 6'd9, 6'd3, 6'd5, 6'd9};
        run_meas(20);
        chk("rs_busy1",    32'(busy1),   32'd1);
        chk("rs_done1",    32'(done1),   32'd0);
        chk("rs_match1",   32'(match1),  32'd0);
        chk("short_edges", 32'(edges),   32'd4);
        chk("short_per",   32'(period),  32'd3);
        chk("short_match", 32'(match),   32'd1);
        chk("short_max",   32'(maximal), 32'd0);
        chk("short_lock",  32'(lockup),  32'd0);

        // Start pulsed mid-COUNT must be ignored
        poke = 1;
        run_meas(20);
        poke = -1;
        chk("ign_edges", 32'(edges),  32'd4);
        chk("ign_per",   32'(period), 32'd3);
        chk("ign_match", 32'(match),  32'd1);

        // Lock-up during counting
        pat = '{6'd5, 6'd9, 6'd0, 6'd0};
        run_meas(20);
        chk("lock_edges", 32'(edges),  32'd3);
        chk("lock_flag",  32'(lockup), 32'd1);
        chk("lock_per",   32'(period), 32'd2);
        chk("lock_match", 32'(match),  32'd0);

        // Start on an all-zero state
        pat = '{6'd0};
        run_meas(20);
        chk("zero_edges", 32'(edges),  32'd1);
        chk("zero_lock",  32'(lockup), 32'd1);
        chk("zero_per",   32'(period), 32'd0);
        chk("zero_busy",  32'(busy),   32'd0);

        // Timeout: 1,2,...,63 then hold 63; never returns to 1
        pat.delete();
        for (int k = 0; k < 70; k++) pat.push_back((k < 63) ? 6'(k + 1) : 6'd63);
        run_meas(200);
        chk("to_edges", 32'(edges),   32'd65);
        chk("to_flag",  32'(timeout), 32'd1);
        chk("to_per",   32'(period),  32'd64);
        chk("to_match", 32'(match),   32'd0);
        chk("to_lock",  32'(lockup),  32'd0);
        chk("to_max",   32'(maximal), 32'd0);

        // Asynchronous reset in the middle of COUNT
        @(negedge clk);
        lfsr_in = 6'd1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lfsr_in = 6'd2;
        @(negedge clk);
        lfsr_in = 6'd3;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_done",   32'(done),   32'd0);
        chk("arst_period", 32'(period), 32'd0);
        chk("arst_flags",  32'({match, lockup, timeout, maximal}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pat = '{6'd5, 6'd9, 6'd3, 6'd5, 6'd9};
        run_meas(20);
        chk("post_edges", 32'(edges),  32'd4);
        chk("post_per",   32'(period), 32'd3);
        chk("post_match", 32'(match),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
